stage_e_md: RTL and testbench
=============================

# stage_e_md

Parametrised execute stage for the combined ARM/RISC-V pipeline. It holds the D→E pipeline register, the two 3-way operand-forwarding muxes, the immediate mux and a single-cycle ALU. It adds an iterative multiply/divide unit (MDU) whose multi-cycle occupancy of E is signalled to the hazard unit through `MdBusyE`. It sits between `stage_d` and `stage_m`, and its outputs feed the M pipeline register unchanged.

## Interface
- `XLEN`, 32: datapath width; even, ≥8.
- `RADDR`, 5: register-address width.
- `MD_BPC`, 1: MDU bits retired per cycle; 1, 2 or 4; must divide `XLEN`.
- Reset is synchronous and active-high on a single clock. All flops update on the rising edge of `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `Rd1D`, `Rd2D`, `immextD`, `PCPlus4D` in XLEN: D-stage operands.
- `RdD`, `Rs1D`, `Rs2D` in RADDR: register addresses.
- `RegWriteD`, `MemWriteD`, `ALUSrcD`, `armD` in 1: control inputs.
- `ResultSrcD` in 2: result-source select; carried through only.
- `OpD` in 4: `exop_t` operation code.
- `FlushE`, `StallE` in 1: hazard-unit controls.
- `ForwardAE`, `ForwardBE` in 2: forward selects. 0 = register file, 1 = `ResultW`, 2 = `ALUResultM`.
- `ALUResultM`, `ResultW` in XLEN: forwarding sources.
- `RdE`, `Rs1E`, `Rs2E` out RADDR.
- `RegWriteE`, `MemWriteE`, `armE` out 1.
- `ResultSrcE` out 2.
- `PCPlus4E`, `WriteDataE`, `ExResultE` out XLEN.
- `MdBusyE` out 1: MDU holds E; the hazard unit must stall F/D and bubble M.

## Operation
- **E register:**
  - `rst` or `FlushE`: clear to all-zero (bubble).
  - Else if `StallE | MdBusyE`: hold.
  - Else: load D inputs.
- **Operands:**
  - Op1 = fwd(`Rd1E`).
  - `WriteDataE` = fwd(`Rd2E`).
  - Op2 = `ALUSrcE` ? `immextE` : `WriteDataE`.
- **ALU ops** (single cycle, combinational to `ExResultE`):
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - SLT=5 (signed), SLTU=6: result 1 or 0, zero-extended.
  - PASSB=7.
- **MDU ops:** MUL=8 (low XLEN bits), MULH=9, MULHU=10, DIV=11, DIVU=12, REM=13, REMU=14.
- **Reserved op** 15: result 0, no stall.
- **Signed MDU ops:** iterate on magnitudes, then negate the result where signs require it. The remainder takes the sign of the dividend.
- **Divide by zero:** DIV/DIVU return all-ones; REM/REMU return the dividend.
- **Signed overflow** (DIV of min-negative by −1): quotient = min-negative, REM = 0.
- **MDU FSM**, states IDLE, RUN, DONE:
  - IDLE: if `OpE` is an MDU op, not flushed and not reset, capture post-forwarding Op1/Op2, clear the counter and go to RUN. `MdBusyE` = 1 this cycle.
  - RUN: retire `MD_BPC` bits per cycle for N = `XLEN/MD_BPC` cycles, then go to DONE. `MdBusyE` = 1.
  - DONE: `MdBusyE` = 0 and `ExResultE` = MDU result. Go to IDLE on the edge where the E register loads. Stay in DONE while `StallE` is high.
- `armE` only travels through the register. ARM MUL uses op 8 and behaves identically.

## Timing
- Reset values:
  - All E-register outputs are 0.
  - `ExResultE`, `WriteDataE` and `PCPlus4E` are 0.
  - `MdBusyE` = 0 and the FSM is in IDLE.
- ALU ops have 0 extra cycles in E.
- MDU ops occupy E for N+2 cycles (IDLE capture, N RUN, DONE). With defaults that is 34 cycles.
- Operands are captured in the IDLE cycle, so later changes on `ALUResultM`/`ResultW` are ignored.
- `FlushE` in any state: bubble the register and force IDLE on the same edge. `MdBusyE` is 0 the next cycle.
- `rst` mid-operation: same as `FlushE`.
- Back-to-back MDU ops: the second enters E on the DONE edge and starts its own IDLE capture the next cycle.

## Configuration
- Macro `STAGE_E_DIV_EN`.
- Defined: full MDU as above.
- Undefined:
  - Divider datapath omitted.
  - Ops 11–14 behave as reserved: result 0, no stall.
  - MUL/MULH/MULHU latency is unchanged.

## Structure
- `stage_e_pkg` holds:
  - `exop_t` enum (4-bit).
  - `md_state_t` enum.
  - `FWD_RF`/`FWD_W`/`FWD_M` constants.
- One sub-module, `md_iter`, parametrised by `XLEN` and `MD_BPC`. It owns the FSM, counter, shift/accumulate registers and sign fix-up, and has a start/op/a/b in, busy/result out interface.
- The E register uses the codebase's `flopr`-style reset register with an added enable.

## Test plan
- ADD, Rd1=5, imm=−7, `ALUSrcD`=1 → `ExResultE`=0xFFFFFFFE next cycle, `MdBusyE` never high.
- `ForwardAE`=2, `ALUResultM`=0x10, Rd2=3, SUB → 0xD; `ForwardBE`=1, `ResultW`=9 → `WriteDataE`=9.
- MULH 0x80000000 × 2 → 0xFFFFFFFF. `MdBusyE` is high for exactly 33 cycles, with the result valid in the DONE cycle.
- DIV −7/2 → −3; REM → −1. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. DIV 0x80000000/−1 → 0x80000000.
- `FlushE` on RUN cycle 10 → bubble, `MdBusyE`=0 next cycle. A following ADD completes normally.
- `STAGE_E_DIV_EN` undefined: DIV → result 0 with no stall; MUL 6×7 → 42 after 34 cycles.

Source files
------------

// File: rtl/stage_e_pkg.sv
`default_nettype none
// ============================================================================
// stage_e_pkg : op codes, MDU state and forward-select constants for stage_e_md
// Optional divider enabled by STAGE_E_DIV_EN.   Revision: 1.0
// ============================================================================
package stage_e_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_PASSB = 4'd7,
    OP_MUL   = 4'd8,
    OP_MULH  = 4'd9,
    OP_MULHU = 4'd10,
    OP_DIV   = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REM   = 4'd13,
    OP_REMU  = 4'd14,
    OP_RSVD  = 4'd15
  } exop_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  function automatic logic is_md_op(input exop_t op);
`ifdef STAGE_E_DIV_EN
    return (op >= OP_MUL) && (op <= OP_REMU);
`else
    return (op >= OP_MUL) && (op <= OP_MULHU);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_e_md_md_iter.sv
`default_nettype none
// ============================================================================
// md_iter : iterative multiply/divide unit, MD_BPC bits retired per cycle
// Divider datapath present only with STAGE_E_DIV_EN.   Revision: 1.0
// ============================================================================
module md_iter
  import stage_e_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MD_BPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            start_i,
  input  exop_t           op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N  = XLEN / MD_BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  md_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q;
  exop_t                 op_q;
  logic                  neg_q;
  logic [XLEN-1:0]       mcand_q;
  logic [2*XLEN-1:0]     prod_q;

  logic                  w_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0]       w_ma, w_mb;
  logic [XLEN+MD_BPC-1:0] w_pp, w_sum;
  logic [2*XLEN-1:0]     w_prod_nx, w_prod_s;

  // Signed ops iterate on magnitudes; neg_q records the final sign flip.
  assign w_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_sa     = w_signed & a_i[XLEN-1];
  assign w_sb     = w_signed & b_i[XLEN-1];
  assign w_ma     = w_sa ? -a_i : a_i;
  assign w_mb     = w_sb ? -b_i : b_i;
  assign w_neg    = (op_i == OP_REM) ? w_sa : (w_sa ^ w_sb);

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_RUN;
          busy_o  = 1'b1;
        end
      end
      MD_RUN: begin
        busy_o = 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = MD_DONE;
      end
      MD_DONE: begin
        done_o = 1'b1;
        if (!stall_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Shift-add multiplier: multiplier bits are consumed from the low half of prod_q.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < MD_BPC; i++) begin
      if (prod_q[i]) w_pp = w_pp + ({{MD_BPC{1'b0}}, mcand_q} << i);
    end
    w_sum = {{MD_BPC{1'b0}}, prod_q[2*XLEN-1:XLEN]} + w_pp;
  end

  assign w_prod_nx = {w_sum, prod_q[XLEN-1:MD_BPC]};
  assign w_prod_s  = neg_q ? -prod_q : prod_q;

`ifdef STAGE_E_DIV_EN
  logic [XLEN-1:0] dvsr_q, quo_q, rem_q;
  logic            bzero_q;
  logic [XLEN:0]   w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;

  // Restoring division, MD_BPC radix-2 steps per cycle.
  always_comb begin
    w_rem_nx = {1'b0, rem_q};
    w_quo_nx = quo_q;
    for (int i = 0; i < MD_BPC; i++) begin
      w_rem_nx = {w_rem_nx[XLEN-1:0], w_quo_nx[XLEN-1]};
      w_quo_nx = {w_quo_nx[XLEN-2:0], 1'b0};
      if (w_rem_nx >= {1'b0, dvsr_q}) begin
        w_rem_nx    = w_rem_nx - {1'b0, dvsr_q};
        w_quo_nx[0] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
`ifdef STAGE_E_DIV_EN
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      bzero_q <= 1'b0;
`endif
    end else if ((state_q == MD_IDLE) && start_i) begin
      cnt_q   <= '0;
      op_q    <= op_i;
      neg_q   <= w_neg;
      mcand_q <= w_ma;
      prod_q  <= {{XLEN{1'b0}}, w_mb};
`ifdef STAGE_E_DIV_EN
      dvsr_q  <= w_mb;
      quo_q   <= w_ma;
      rem_q   <= '0;
      bzero_q <= (b_i == '0);
`endif
    end else if (state_q == MD_RUN) begin
      cnt_q   <= cnt_q + CW'(1);
      prod_q  <= w_prod_nx;
`ifdef STAGE_E_DIV_EN
      quo_q   <= w_quo_nx;
      rem_q   <= w_rem_nx[XLEN-1:0];
`endif
    end
  end

  always_comb begin
    result_o = '0;
    case (op_q)
      OP_MUL:   result_o = prod_q[XLEN-1:0];
      OP_MULH:  result_o = w_prod_s[2*XLEN-1:XLEN];
      OP_MULHU: result_o = prod_q[2*XLEN-1:XLEN];
`ifdef STAGE_E_DIV_EN
      OP_DIV:   result_o = bzero_q ? '1 : (neg_q ? -quo_q : quo_q);
      OP_DIVU:  result_o = bzero_q ? '1 : quo_q;
      OP_REM:   result_o = neg_q ? -rem_q : rem_q;
      OP_REMU:  result_o = rem_q;
`endif
      default:  result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stage_e_md.sv
`default_nettype none
// ============================================================================
// stage_e_md : execute stage (E register, forwarding, ALU, iterative MDU)
// Divide/remainder ops enabled by STAGE_E_DIV_EN.   Revision: 1.0
// ============================================================================
module stage_e_md
  import stage_e_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RADDR  = 5,
  parameter int MD_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  Rd1D,
  input  logic [XLEN-1:0]  Rd2D,
  input  logic [XLEN-1:0]  immextD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [RADDR-1:0] RdD,
  input  logic [RADDR-1:0] Rs1D,
  input  logic [RADDR-1:0] Rs2D,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             armD,
  input  logic [1:0]       ResultSrcD,
  input  logic [3:0]       OpD,
  input  logic             FlushE,
  input  logic             StallE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ResultW,
  output logic [RADDR-1:0] RdE,
  output logic [RADDR-1:0] Rs1E,
  output logic [RADDR-1:0] Rs2E,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             armE,
  output logic [1:0]       ResultSrcE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  WriteDataE,
  output logic [XLEN-1:0]  ExResultE,
  output logic             MdBusyE
);

  logic [XLEN-1:0]  rd1_q, rd2_q, imm_q, pc4_q;
  logic [RADDR-1:0] rd_q, rs1_q, rs2_q;
  logic             regw_q, memw_q, alusrc_q, arm_q;
  logic [1:0]       ressrc_q;
  exop_t            op_q;

  logic             w_load, w_md_start, w_md_done;
  logic [XLEN-1:0]  w_op1, w_wd, w_op2, w_alu, w_md_res;

  assign w_load = ~(StallE | MdBusyE);

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      alusrc_q <= 1'b0;
      arm_q    <= 1'b0;
      ressrc_q <= '0;
      op_q     <= OP_ADD;
    end else if (w_load) begin
      rd1_q    <= Rd1D;
      rd2_q    <= Rd2D;
      imm_q    <= immextD;
      pc4_q    <= PCPlus4D;
      rd_q     <= RdD;
      rs1_q    <= Rs1D;
      rs2_q    <= Rs2D;
      regw_q   <= RegWriteD;
      memw_q   <= MemWriteD;
      alusrc_q <= ALUSrcD;
      arm_q    <= armD;
      ressrc_q <= ResultSrcD;
      op_q     <= exop_t'(OpD);
    end
  end

  always_comb begin
    w_op1 = rd1_q;
    case (ForwardAE)
      FWD_W:   w_op1 = ResultW;
      FWD_M:   w_op1 = ALUResultM;
      default: w_op1 = rd1_q;
    endcase
    w_wd = rd2_q;
    case (ForwardBE)
      FWD_W:   w_wd = ResultW;
      FWD_M:   w_wd = ALUResultM;
      default: w_wd = rd2_q;
    endcase
  end

  assign w_op2 = alusrc_q ? imm_q : w_wd;

  always_comb begin
    w_alu = '0;
    case (op_q)
      OP_ADD:   w_alu = w_op1 + w_op2;
      OP_SUB:   w_alu = w_op1 - w_op2;
      OP_AND:   w_alu = w_op1 & w_op2;
      OP_OR:    w_alu = w_op1 | w_op2;
      OP_XOR:   w_alu = w_op1 ^ w_op2;
      OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
      OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
      OP_PASSB: w_alu = w_op2;
      default:  w_alu = '0;
    endcase
  end

  // A flushed or resetting MDU op must not raise MdBusyE in its capture cycle.
  assign w_md_start = is_md_op(op_q) & ~FlushE & ~rst;

  md_iter #(
    .XLEN   (XLEN),
    .MD_BPC (MD_BPC)
  ) u_md_iter (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (FlushE),
    .stall_i  (StallE),
    .start_i  (w_md_start),
    .op_i     (op_q),
    .a_i      (w_op1),
    .b_i      (w_op2),
    .busy_o   (MdBusyE),
    .done_o   (w_md_done),
    .result_o (w_md_res)
  );

  assign ExResultE  = w_md_done ? w_md_res : w_alu;
  assign WriteDataE = w_wd;
  assign PCPlus4E   = pc4_q;
  assign RdE        = rd_q;
  assign Rs1E       = rs1_q;
  assign Rs2E       = rs2_q;
  assign RegWriteE  = regw_q;
  assign MemWriteE  = memw_q;
  assign armE       = arm_q;
  assign ResultSrcE = ressrc_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_e_md.sv
`default_nettype none
// tb_stage_e_md : self-checking bench for stage_e_md; define STAGE_E_DIV_EN to
// expect the divider, otherwise ops 11-14 are expected to act as reserved.
module tb_stage_e_md;

  localparam int XLEN   = 32;
  localparam int RADDR  = 5;
  localparam int MD_BPC = 1;
  localparam int N_RUN  = XLEN / MD_BPC;
`ifdef STAGE_E_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [XLEN-1:0]  Rd1D, Rd2D, immextD, PCPlus4D;
  logic [RADDR-1:0] RdD, Rs1D, Rs2D;
  logic             RegWriteD, MemWriteD, ALUSrcD, armD;
  logic [1:0]       ResultSrcD;
  logic [3:0]       OpD;
  logic             FlushE, StallE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [XLEN-1:0]  ALUResultM, ResultW;
  logic [RADDR-1:0] RdE, Rs1E, Rs2E;
  logic             RegWriteE, MemWriteE, armE;
  logic [1:0]       ResultSrcE;
  logic [XLEN-1:0]  PCPlus4E, WriteDataE, ExResultE;
  logic             MdBusyE;

  stage_e_md #(.XLEN(XLEN), .RADDR(RADDR), .MD_BPC(MD_BPC)) dut (
    .clk(clk), .rst(rst),
    .Rd1D(Rd1D), .Rd2D(Rd2D), .immextD(immextD), .PCPlus4D(PCPlus4D),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .armD(armD),
    .ResultSrcD(ResultSrcD), .OpD(OpD),
    .FlushE(FlushE), .StallE(StallE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .armE(armE),
    .ResultSrcE(ResultSrcE), .PCPlus4E(PCPlus4E),
    .WriteDataE(WriteDataE), .ExResultE(ExResultE), .MdBusyE(MdBusyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: arithmetic straight from the operation rules.
  function automatic logic [31:0] model_res(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     w;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sa < sb) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7: return b;
      8: begin w = sa * sb; return w[31:0]; end
      9: begin w = sa * sb; return w[63:32]; end
      10: begin w = ua * ub; return w[63:32]; end
      11: begin
        if (!DIV_EN) return 32'd0;
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        w = sa / sb; return w[31:0];
      end
      12: begin
        if (!DIV_EN) return 32'd0;
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
      end
      13: begin
        if (!DIV_EN) return 32'd0;
        if (b == 0) return a;
        if (ovf) return 32'd0;
        w = sa % sb; return w[31:0];
      end
      14: begin
        if (!DIV_EN) return 32'd0;
        return (b == 0) ? a : a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_md(input int op);
    return (op >= 8 && op <= 10) || (DIV_EN && op >= 11 && op <= 14);
  endfunction

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] m, input logic [31:0] w);
    return (sel == 2'd1) ? w : (sel == 2'd2) ? m : rf;
  endfunction

  task automatic load_md(input int op, input logic [31:0] a, input logic [31:0] b);
    OpD = 4'(op); Rd1D = a; Rd2D = b; ALUSrcD = 1'b0;
    ForwardAE = 2'd0; ForwardBE = 2'd0; RegWriteD = 1'b1;
    tick;
    OpD = 4'd0; Rd1D = '0; Rd2D = '0; RegWriteD = 1'b0;
  endtask

  task automatic wait_md(input int op, input logic [31:0] a, input logic [31:0] b,
                         input int already, input string name);
    int busy;
    busy = already;
    while (MdBusyE === 1'b1 && busy < 200) begin
      busy++;
      tick;
    end
    check({name, "_busy"}, busy, model_md(op) ? N_RUN + 1 : 0);
    check({name, "_res"}, ExResultE, model_res(op, a, b));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] aluM, resW, exp_res, exp_wd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, imm, m, w, op1, op2, wd;
    logic [1:0]  fa, fb;
    logic        src;
    int          op;

    vecs[0] = '{4'd0, 32'd5,        32'h11,   32'hFFFF_FFF9, 1'b1, 2'd0, 2'd0, 32'd0,   32'd0,  32'hFFFF_FFFE, 32'h11};
    vecs[1] = '{4'd1, 32'hAA,       32'd3,    32'd0,         1'b0, 2'd2, 2'd0, 32'h10,  32'd0,  32'hD,         32'd3};
    vecs[2] = '{4'd3, 32'h100,      32'h77,   32'd0,         1'b0, 2'd0, 2'd1, 32'd0,   32'd9,  32'h109,       32'd9};
    vecs[3] = '{4'd5, 32'hFFFF_FFFF, 32'd1,   32'd0,         1'b0, 2'd0, 2'd0, 32'd0,   32'd0,  32'd1,         32'd1};
    vecs[4] = '{4'd6, 32'hFFFF_FFFF, 32'd1,   32'd0,         1'b0, 2'd0, 2'd0, 32'd0,   32'd0,  32'd0,         32'd1};
    vecs[5] = '{4'd7, 32'h55,       32'h66,   32'h1234,      1'b1, 2'd0, 2'd0, 32'd0,   32'd0,  32'h1234,      32'h66};
    vecs[6] = '{4'd4, 32'hF0F0,     32'hFF00, 32'd0,         1'b0, 2'd0, 2'd0, 32'd0,   32'd0,  32'h0FF0,      32'hFF00};
    vecs[7] = '{4'd2, 32'hF0F0,     32'hFF00, 32'd0,         1'b0, 2'd0, 2'd0, 32'd0,   32'd0,  32'hF000,      32'hFF00};
    vecs[8] = '{4'd15, 32'd3,       32'd4,    32'd0,         1'b0, 2'd0, 2'd0, 32'd0,   32'd0,  32'd0,         32'd4};
    vecs[9] = '{4'd0, 32'd1,        32'd2,    32'd5,         1'b1, 2'd1, 2'd2, 32'h77,  32'h20, 32'h25,        32'h77};

    // Nonzero D-side values during reset make the bubble check meaningful.
    rst = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    Rd1D = 32'h1111; Rd2D = 32'h2222; immextD = 32'h3333; PCPlus4D = 32'h44;
    RdD = 5'd5; Rs1D = 5'd6; Rs2D = 5'd7; RegWriteD = 1'b1; MemWriteD = 1'b1;
    ALUSrcD = 1'b0; armD = 1'b1; ResultSrcD = 2'd2; OpD = 4'd0;
    ForwardAE = 2'd0; ForwardBE = 2'd0; ALUResultM = '0; ResultW = '0;
    repeat (3) tick;
    check("rst_ExResultE", ExResultE, 32'd0);
    check("rst_WriteDataE", WriteDataE, 32'd0);
    check("rst_PCPlus4E", PCPlus4E, 32'd0);
    check("rst_RdE", 32'(RdE), 32'd0);
    check("rst_RegWriteE", 32'(RegWriteE), 32'd0);
    check("rst_armE", 32'(armE), 32'd0);
    check("rst_MdBusyE", 32'(MdBusyE), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      OpD = vecs[i].op; Rd1D = vecs[i].rd1; Rd2D = vecs[i].rd2; immextD = vecs[i].imm;
      ALUSrcD = vecs[i].alusrc; ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb;
      ALUResultM = vecs[i].aluM; ResultW = vecs[i].resW;
      RdD = 5'(i + 1); RegWriteD = i[0]; armD = ~i[0]; PCPlus4D = 32'(4 * i + 4);
      tick;
      check($sformatf("vec%0d_res", i), ExResultE, vecs[i].exp_res);
      check($sformatf("vec%0d_wd", i), WriteDataE, vecs[i].exp_wd);
      check($sformatf("vec%0d_busy", i), 32'(MdBusyE), 32'd0);
      check($sformatf("vec%0d_rd", i), 32'(RdE), 32'(i + 1));
      check($sformatf("vec%0d_pc4", i), PCPlus4E, 32'(4 * i + 4));
      check($sformatf("vec%0d_ctl", i), {30'd0, RegWriteE, armE}, {30'd0, i[0], ~i[0]});
    end

    for (int k = 0; k < 24; k++) begin
      op = int'($urandom_range(0, 7));
      a = $urandom; b = $urandom; imm = $urandom; m = $urandom; w = $urandom;
      if (k % 4 == 0) b = a;
      src = 1'($urandom_range(0, 1));
      fa = 2'($urandom_range(0, 2)); fb = 2'($urandom_range(0, 2));
      OpD = 4'(op); Rd1D = a; Rd2D = b; immextD = imm; ALUSrcD = src;
      ForwardAE = fa; ForwardBE = fb; ALUResultM = m; ResultW = w;
      tick;
      op1 = model_fwd(fa, a, m, w);
      wd  = model_fwd(fb, b, m, w);
      op2 = src ? imm : wd;
      check($sformatf("rand%0d_op%0d_res", k, op), ExResultE, model_res(op, op1, op2));
      check($sformatf("rand%0d_wd", k), WriteDataE, wd);
    end
    ForwardAE = 2'd0; ForwardBE = 2'd0; immextD = '0;

    load_md(9, 32'h8000_0000, 32'd2);      wait_md(9, 32'h8000_0000, 32'd2, 0, "mulh_min");
    load_md(8, 32'd6, 32'd7);              wait_md(8, 32'd6, 32'd7, 0, "mul_6x7");
    load_md(8, 32'hFFFF_FFFD, 32'd5);      wait_md(8, 32'hFFFF_FFFD, 32'd5, 0, "mul_neg");
    load_md(11, 32'hFFFF_FFF9, 32'd2);     wait_md(11, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    load_md(13, 32'hFFFF_FFF9, 32'd2);     wait_md(13, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
    load_md(12, 32'd5, 32'd0);             wait_md(12, 32'd5, 32'd0, 0, "divu_by0");
    load_md(14, 32'd5, 32'd0);             wait_md(14, 32'd5, 32'd0, 0, "remu_by0");
    load_md(11, 32'h8000_0000, 32'hFFFF_FFFF); wait_md(11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    load_md(13, 32'h8000_0000, 32'hFFFF_FFFF); wait_md(13, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    load_md(11, 32'hFFFF_FFFB, 32'd0);     wait_md(11, 32'hFFFF_FFFB, 32'd0, 0, "div_neg_by0");
    load_md(13, 32'hFFFF_FFFB, 32'd0);     wait_md(13, 32'hFFFF_FFFB, 32'd0, 0, "rem_neg_by0");

    for (int k = 0; k < 8; k++) begin
      op = int'($urandom_range(8, 14));
      a = $urandom;
      b = (k % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      load_md(op, a, b);
      wait_md(op, a, b, 0, $sformatf("md_rand%0d_op%0d", k, op));
    end

    // Operands come from forwarding at capture; later ALUResultM changes must not matter.
    OpD = 4'd8; Rd1D = 32'd99; Rd2D = 32'd7; ALUSrcD = 1'b0; ForwardAE = 2'd2; ALUResultM = 32'd6;
    tick;
    OpD = 4'd0; Rd1D = '0; Rd2D = '0;
    check("cap_idle_busy", 32'(MdBusyE), 32'd1);
    tick;
    ALUResultM = 32'd1000;
    wait_md(8, 32'd6, 32'd7, 1, "cap_fwd");
    ForwardAE = 2'd0;

    // Stall while DONE holds the result, then the next instruction loads.
    StallE = 1'b1;
    tick;
    check("stall_done_res", ExResultE, 32'd42);
    check("stall_done_busy", 32'(MdBusyE), 32'd0);
    tick;
    check("stall_done_res2", ExResultE, 32'd42);
    StallE = 1'b0;
    tick;
    check("after_done_res", ExResultE, 32'd0);
    check("after_done_busy", 32'(MdBusyE), 32'd0);

    // Back-to-back MDU ops.
    load_md(8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    OpD = 4'd10; Rd1D = 32'hFFFF_FFFF; Rd2D = 32'hFFFF_FFFF; RegWriteD = 1'b1;
    wait_md(8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "b2b_first");
    tick;
    OpD = 4'd0; Rd1D = '0; Rd2D = '0; RegWriteD = 1'b0;
    wait_md(10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "b2b_second");

    // Flush on RUN cycle 10, then an ADD runs normally.
    load_md(8, 32'd3, 32'd5);
    repeat (10) tick;
    check("flush_pre_busy", 32'(MdBusyE), 32'd1);
    OpD = 4'd0; Rd1D = 32'd2; Rd2D = 32'd3; RegWriteD = 1'b1; RdD = 5'd3;
    FlushE = 1'b1;
    tick;
    FlushE = 1'b0;
    check("flush_busy", 32'(MdBusyE), 32'd0);
    check("flush_regwrite", 32'(RegWriteE), 32'd0);
    check("flush_res", ExResultE, 32'd0);
    tick;
    check("post_flush_add", ExResultE, 32'd5);
    check("post_flush_busy", 32'(MdBusyE), 32'd0);
    check("post_flush_rd", 32'(RdE), 32'd3);

    // Reset in the middle of an MDU op.
    load_md(9, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_busy", 32'(MdBusyE), 32'd0);
    check("rst_mid_regwrite", 32'(RegWriteE), 32'd0);
    load_md(8, 32'd11, 32'd13);            wait_md(8, 32'd11, 32'd13, 0, "after_rst_mul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
